// File: rtl/sdram_arbiter.sv
// sdram_arbiter: shares the single SDRAM command port between video, CPU and download writers.
// Build option SDRAM_ARB_DLFIFO_EN: 4-entry download FIFO instead of one holding register.
module sdram_arbiter #(
    parameter int unsigned AW         = 23,
    parameter int unsigned DL_MAXSKIP = 3
) (
    input  logic          clk_sys,
    input  logic          reset,
    input  logic          cpu_rd,
    input  logic          cpu_wr,
    input  logic [AW-1:0] cpu_addr,
    input  logic          cpu_bank,
    input  logic [7:0]    cpu_din,
    output logic [7:0]    cpu_dout,
    output logic          cpu_busy,
    input  logic          vid_req,
    input  logic [15:0]   vid_addr,
    output logic [7:0]    vid_dout,
    output logic          vid_valid,
    input  logic          dl_wr,
    input  logic [AW-1:0] dl_addr,
    input  logic          dl_bank,
    input  logic [7:0]    dl_din,
    output logic          dl_ready,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic          mem_bank,
    output logic [7:0]    mem_din,
    input  logic          mem_ack,
    input  logic [7:0]    mem_dout
);

    typedef enum logic {StIdle, StWait} state_e;
    typedef enum logic [1:0] {SrcVid, SrcCpu, SrcDl} src_e;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic          bank;
        logic [7:0]    din;
    } dl_ent_t;

    localparam logic [2:0] SkipMax = 3'(DL_MAXSKIP);

    state_e        state_q, state_d;
    src_e          src_q, src_d;
    logic          cpu_rd_dly_q, cpu_rd_dly_d, cpu_wr_dly_q, cpu_wr_dly_d;
    logic          cpu_pend_q, cpu_pend_d, cpu_infl_q, cpu_infl_d;
    logic          cpu_we_q, cpu_we_d;
    logic [AW-1:0] cpu_addr_q, cpu_addr_d;
    logic          cpu_bank_q, cpu_bank_d;
    logic [7:0]    cpu_din_q, cpu_din_d;
    logic          vid_pend_q, vid_pend_d;
    logic [15:0]   vid_addr_q, vid_addr_d;
    logic [2:0]    dl_skip_q, dl_skip_d;
    logic          mem_req_q, mem_req_d, mem_we_q, mem_we_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic          mem_bank_q, mem_bank_d;
    logic [7:0]    mem_din_q, mem_din_d;
    logic [7:0]    cpu_dout_q, cpu_dout_d, vid_dout_q, vid_dout_d;
    logic          cpu_busy_q, cpu_busy_d, vid_valid_q, vid_valid_d;

    logic          gnt_vid, gnt_cpu, gnt_dl;
    logic          rd_rise, wr_rise;
    logic          dl_pend, dl_push, dl_pop;
    dl_ent_t       dl_head;

    assign dl_push = dl_wr & dl_ready;
    assign dl_pop  = gnt_dl;

`ifdef SDRAM_ARB_DLFIFO_EN
    dl_ent_t    fifo_q [4];
    dl_ent_t    fifo_d [4];
    logic [1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [2:0] cnt_q, cnt_d;

    assign dl_pend  = (cnt_q != 3'd0);
    assign dl_ready = (cnt_q != 3'd4);
    assign dl_head  = fifo_q[rptr_q];

    always_comb begin
        fifo_d = fifo_q;
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (dl_push) begin
            fifo_d[wptr_q] = '{addr: dl_addr, bank: dl_bank, din: dl_din};
            wptr_d         = wptr_q + 2'd1;
        end
        if (dl_pop) begin
            rptr_d = rptr_q + 2'd1;
        end
        cnt_d = cnt_q + {2'b00, dl_push} - {2'b00, dl_pop};
    end

    // Entry storage needs no reset; emptiness lives in the pointers and count.
    always_ff @(posedge clk_sys) begin
        fifo_q <= fifo_d;
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end
`else
    dl_ent_t hold_q, hold_d;
    logic    dl_pend_q, dl_pend_d;

    assign dl_pend  = dl_pend_q;
    assign dl_ready = ~dl_pend_q;
    assign dl_head  = hold_q;

    always_comb begin
        hold_d    = hold_q;
        dl_pend_d = dl_pend_q;
        if (dl_pop) begin
            dl_pend_d = 1'b0;
        end
        if (dl_push) begin
            hold_d    = '{addr: dl_addr, bank: dl_bank, din: dl_din};
            dl_pend_d = 1'b1;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            hold_q    <= '0;
            dl_pend_q <= 1'b0;
        end else begin
            hold_q    <= hold_d;
            dl_pend_q <= dl_pend_d;
        end
    end
`endif

    assign rd_rise = cpu_rd & ~cpu_rd_dly_q;
    assign wr_rise = cpu_wr & ~cpu_wr_dly_q;

    always_comb begin
        gnt_vid = 1'b0;
        gnt_cpu = 1'b0;
        gnt_dl  = 1'b0;
        if (state_q == StIdle) begin
            if (dl_pend && (dl_skip_q == SkipMax)) begin
                gnt_dl = 1'b1;
            end else if (vid_pend_q) begin
                gnt_vid = 1'b1;
            end else if (cpu_pend_q) begin
                gnt_cpu = 1'b1;
            end else if (dl_pend) begin
                gnt_dl = 1'b1;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        src_d        = src_q;
        cpu_rd_dly_d = cpu_rd;
        cpu_wr_dly_d = cpu_wr;
        cpu_pend_d   = cpu_pend_q;
        cpu_infl_d   = cpu_infl_q;
        cpu_we_d     = cpu_we_q;
        cpu_addr_d   = cpu_addr_q;
        cpu_bank_d   = cpu_bank_q;
        cpu_din_d    = cpu_din_q;
        vid_pend_d   = vid_pend_q;
        vid_addr_d   = vid_addr_q;
        dl_skip_d    = dl_skip_q;
        mem_req_d    = 1'b0;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_bank_d   = mem_bank_q;
        mem_din_d    = mem_din_q;
        cpu_dout_d   = cpu_dout_q;
        vid_dout_d   = vid_dout_q;
        vid_valid_d  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (gnt_vid || gnt_cpu || gnt_dl) begin
                    state_d   = StWait;
                    mem_req_d = 1'b1;
                end
                if (gnt_vid) begin
                    src_d      = SrcVid;
                    vid_pend_d = 1'b0;
                    mem_we_d   = 1'b0;
                    mem_addr_d = AW'({2'b10, vid_addr_q});
                    mem_bank_d = 1'b0;
                    mem_din_d  = 8'h00;
                end else if (gnt_cpu) begin
                    src_d      = SrcCpu;
                    cpu_pend_d = 1'b0;
                    cpu_infl_d = 1'b1;
                    mem_we_d   = cpu_we_q;
                    mem_addr_d = cpu_addr_q;
                    mem_bank_d = cpu_bank_q;
                    mem_din_d  = cpu_din_q;
                end else if (gnt_dl) begin
                    src_d      = SrcDl;
                    mem_we_d   = 1'b1;
                    mem_addr_d = dl_head.addr;
                    mem_bank_d = dl_head.bank;
                    mem_din_d  = dl_head.din;
                end
            end
            StWait: begin
                if (mem_ack) begin
                    state_d = StIdle;
                    if (src_q == SrcVid) begin
                        vid_dout_d  = mem_dout;
                        vid_valid_d = 1'b1;
                    end else if (src_q == SrcCpu) begin
                        cpu_infl_d = 1'b0;
                        if (!mem_we_q) begin
                            cpu_dout_d = mem_dout;
                        end
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        if (!dl_pend || gnt_dl) begin
            dl_skip_d = '0;
        end else if (gnt_vid || gnt_cpu) begin
            dl_skip_d = dl_skip_q + 3'd1;
        end

        // A fresh video request after the grant re-arms pending; newest address wins.
        if (vid_req) begin
            vid_pend_d = 1'b1;
            vid_addr_d = vid_addr;
        end

        if ((rd_rise || wr_rise) && !cpu_pend_q && !cpu_infl_q) begin
            cpu_pend_d = 1'b1;
            cpu_we_d   = wr_rise;
            cpu_addr_d = cpu_addr;
            cpu_bank_d = cpu_bank;
            cpu_din_d  = cpu_din;
        end

        cpu_busy_d = cpu_pend_d | cpu_infl_d;
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q      <= StIdle;
            src_q        <= SrcVid;
            cpu_rd_dly_q <= 1'b0;
            cpu_wr_dly_q <= 1'b0;
            cpu_pend_q   <= 1'b0;
            cpu_infl_q   <= 1'b0;
            cpu_we_q     <= 1'b0;
            cpu_addr_q   <= '0;
            cpu_bank_q   <= 1'b0;
            cpu_din_q    <= 8'h00;
            vid_pend_q   <= 1'b0;
            vid_addr_q   <= 16'h0000;
            dl_skip_q    <= '0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_bank_q   <= 1'b0;
            mem_din_q    <= 8'h00;
            cpu_dout_q   <= 8'hFF;
            vid_dout_q   <= 8'hFF;
            cpu_busy_q   <= 1'b0;
            vid_valid_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            src_q        <= src_d;
            cpu_rd_dly_q <= cpu_rd_dly_d;
            cpu_wr_dly_q <= cpu_wr_dly_d;
            cpu_pend_q   <= cpu_pend_d;
            cpu_infl_q   <= cpu_infl_d;
            cpu_we_q     <= cpu_we_d;
            cpu_addr_q   <= cpu_addr_d;
            cpu_bank_q   <= cpu_bank_d;
            cpu_din_q    <= cpu_din_d;
            vid_pend_q   <= vid_pend_d;
            vid_addr_q   <= vid_addr_d;
            dl_skip_q    <= dl_skip_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_bank_q   <= mem_bank_d;
            mem_din_q    <= mem_din_d;
            cpu_dout_q   <= cpu_dout_d;
            vid_dout_q   <= vid_dout_d;
            cpu_busy_q   <= cpu_busy_d;
            vid_valid_q  <= vid_valid_d;
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_bank  = mem_bank_q;
    assign mem_din   = mem_din_q;
    assign cpu_dout  = cpu_dout_q;
    assign vid_dout  = vid_dout_q;
    assign cpu_busy  = cpu_busy_q;
    assign vid_valid = vid_valid_q;

endmodule
